// File: rtl/mem_transfer_unit_if.sv
// Bus bundle for mem_transfer_unit: arbiter handshake, UART byte streams and word memory port.
// master = the transfer unit, slave = the surrounding arbiter/UART/memory.
interface mem_transfer_unit_if #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 32,
   parameter int TGT_W      = 2
);
   logic                    grant_i;
   logic                    done_o;
   logic [TGT_W-1:0]        target_o;
   logic [7:0]              rx_data_i;
   logic                    rx_ready_i;
   logic [7:0]              tx_data_o;
   logic                    tx_start_o;
   logic                    tx_done_i;
   logic                    mem_we_o;
   logic                    mem_re_o;
   logic [ADDR_W-1:0]       mem_addr_o;
   logic [8*WORD_BYTES-1:0] mem_wdata_o;
   logic [8*WORD_BYTES-1:0] mem_rdata_i;

   modport master (
      input  grant_i, rx_data_i, rx_ready_i, tx_done_i, mem_rdata_i,
      output done_o, target_o, tx_data_o, tx_start_o,
             mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o
   );

   modport slave (
      output grant_i, rx_data_i, rx_ready_i, tx_done_i, mem_rdata_i,
      input  done_o, target_o, tx_data_o, tx_start_o,
             mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_transfer_unit.sv
// UART-driven memory load/dump engine: command, word count, payload with XOR checksum,
// then a one-byte completion code. All outputs are registered.
module mem_transfer_unit #(
   parameter int         WORD_BYTES = 4,
   parameter int         ADDR_W     = 32,
   parameter int         COUNT_W    = 16,
   parameter int         TGT_W      = 2,
   parameter logic [7:0] ACK_OK     = 8'hF1,
   parameter logic [7:0] ACK_ERR    = 8'hE1
) (
   input logic                clk_i,
   input logic                rst_i,
   mem_transfer_unit_if.master bus
);
   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int CNT_BYTES = COUNT_W / 8;
   localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int CI_W = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_CNT, S_RX_BYTE, S_WRITE, S_RX_CSUM, S_READ,
      S_TX_BYTE, S_TX_WAIT, S_TX_CSUM, S_CSUM_WAIT, S_ACK, S_ACK_WAIT, S_DONE
   } state_t;

   state_t              state_reg;
   logic                mode_reg;
   logic                ok_reg;
   logic [TGT_W-1:0]    target_reg;
   logic [COUNT_W-1:0]  count_reg;
   logic [COUNT_W-1:0]  words_reg;
   logic [CI_W-1:0]     cnt_idx_reg;
   logic [BI_W-1:0]     byte_idx_reg;
   logic [WORD_W-1:0]   word_reg;
   logic [7:0]          csum_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                done_reg, mem_we_reg, mem_re_reg, tx_start_reg;
   logic [7:0]          tx_data_reg;
   logic [WORD_W-1:0]   mem_wdata_reg;

   logic [COUNT_W-1:0]  count_next;
   logic [COUNT_W-1:0]  words_next;
   logic [WORD_W-1:0]   word_next;
   logic [WORD_W-1:0]   tx_word;
   logic [7:0]          tx_bytes [WORD_BYTES];
   logic [7:0]          tx_byte;
   logic                last_byte;
   logic                last_cnt_byte;

   generate
      if (COUNT_W > 8) begin : g_cnt_wide
         assign count_next = {count_reg[COUNT_W-9:0], bus.rx_data_i};
      end else begin : g_cnt_narrow
         assign count_next = bus.rx_data_i;
      end
   endgenerate

   // Byte 0 of a dumped word comes straight from the memory read port; later bytes from the capture.
   assign tx_word = (byte_idx_reg == '0) ? bus.mem_rdata_i : word_reg;

   generate
      for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lanes
         assign word_next[8*gi +: 8] = (byte_idx_reg == BI_W'(gi)) ? bus.rx_data_i
                                                                    : word_reg[8*gi +: 8];
         assign tx_bytes[gi] = tx_word[8*gi +: 8];
      end
   endgenerate

   assign tx_byte       = tx_bytes[byte_idx_reg];
   assign words_next    = words_reg + 1'b1;
   assign last_byte     = (byte_idx_reg == BI_W'(WORD_BYTES - 1));
   assign last_cnt_byte = (cnt_idx_reg == CI_W'(CNT_BYTES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= S_IDLE;
         mode_reg      <= 1'b0;
         ok_reg        <= 1'b0;
         target_reg    <= '0;
         count_reg     <= '0;
         words_reg     <= '0;
         cnt_idx_reg   <= '0;
         byte_idx_reg  <= '0;
         word_reg      <= '0;
         csum_reg      <= '0;
         addr_reg      <= '0;
         done_reg      <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_re_reg    <= 1'b0;
         tx_start_reg  <= 1'b0;
         tx_data_reg   <= '0;
         mem_wdata_reg <= '0;
      end else begin
         mem_we_reg   <= 1'b0;
         mem_re_reg   <= 1'b0;
         tx_start_reg <= 1'b0;
         if (!bus.grant_i && state_reg != S_IDLE && state_reg != S_DONE) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
         end else begin
            case (state_reg)
               S_IDLE: if (bus.grant_i) begin
                  addr_reg     <= '0;
                  words_reg    <= '0;
                  count_reg    <= '0;
                  cnt_idx_reg  <= '0;
                  byte_idx_reg <= '0;
                  csum_reg     <= '0;
                  state_reg    <= S_CMD;
               end
               S_CMD: if (bus.rx_ready_i) begin
                  mode_reg   <= bus.rx_data_i[0];
                  target_reg <= bus.rx_data_i[TGT_W:1];
                  state_reg  <= S_CNT;
               end
               S_CNT: if (bus.rx_ready_i) begin
                  count_reg   <= count_next;
                  cnt_idx_reg <= cnt_idx_reg + 1'b1;
                  if (last_cnt_byte) begin
                     cnt_idx_reg <= '0;
                     if (count_next == '0) begin
                        ok_reg    <= 1'b1;
                        state_reg <= S_ACK;
                     end else if (mode_reg) begin
                        mem_re_reg <= 1'b1;
                        state_reg  <= S_READ;
                     end else begin
                        state_reg <= S_RX_BYTE;
                     end
                  end
               end
               S_RX_BYTE: if (bus.rx_ready_i) begin
                  word_reg     <= word_next;
                  csum_reg     <= csum_reg ^ bus.rx_data_i;
                  byte_idx_reg <= byte_idx_reg + 1'b1;
                  if (last_byte) begin
                     byte_idx_reg  <= '0;
                     mem_wdata_reg <= word_next;
                     mem_we_reg    <= 1'b1;
                     state_reg     <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  addr_reg  <= addr_reg + 1'b1;
                  words_reg <= words_next;
                  state_reg <= (words_next == count_reg) ? S_RX_CSUM : S_RX_BYTE;
               end
               S_RX_CSUM: if (bus.rx_ready_i) begin
                  ok_reg    <= (bus.rx_data_i == csum_reg);
                  state_reg <= S_ACK;
               end
               S_READ: state_reg <= S_TX_BYTE;
               S_TX_BYTE: begin
                  if (byte_idx_reg == '0) word_reg <= bus.mem_rdata_i;
                  tx_data_reg  <= tx_byte;
                  tx_start_reg <= 1'b1;
                  csum_reg     <= csum_reg ^ tx_byte;
                  state_reg    <= S_TX_WAIT;
               end
               S_TX_WAIT: if (bus.tx_done_i) begin
                  if (last_byte) begin
                     byte_idx_reg <= '0;
                     addr_reg     <= addr_reg + 1'b1;
                     words_reg    <= words_next;
                     if (words_next == count_reg) begin
                        state_reg <= S_TX_CSUM;
                     end else begin
                        mem_re_reg <= 1'b1;
                        state_reg  <= S_READ;
                     end
                  end else begin
                     byte_idx_reg <= byte_idx_reg + 1'b1;
                     state_reg    <= S_TX_BYTE;
                  end
               end
               S_TX_CSUM: begin
                  tx_data_reg  <= csum_reg;
                  tx_start_reg <= 1'b1;
                  state_reg    <= S_CSUM_WAIT;
               end
               S_CSUM_WAIT: if (bus.tx_done_i) begin
                  ok_reg    <= 1'b1;
                  state_reg <= S_ACK;
               end
               S_ACK: begin
                  tx_data_reg  <= ok_reg ? ACK_OK : ACK_ERR;
                  tx_start_reg <= 1'b1;
                  state_reg    <= S_ACK_WAIT;
               end
               S_ACK_WAIT: if (bus.tx_done_i) begin
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end
               S_DONE: begin
                  done_reg <= bus.grant_i;
                  if (!bus.grant_i) state_reg <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.done_o      = done_reg;
   assign bus.target_o    = target_reg;
   assign bus.tx_data_o   = tx_data_reg;
   assign bus.tx_start_o  = tx_start_reg;
   assign bus.mem_we_o    = mem_we_reg;
   assign bus.mem_re_o    = mem_re_reg;
   assign bus.mem_addr_o  = addr_reg;
   assign bus.mem_wdata_o = mem_wdata_reg;
endmodule

// File: tb/tb_mem_transfer_unit.sv
// Directed bench for mem_transfer_unit: vector table of load/dump transfers plus
// hand-written abort and reset-mid-dump sequences, against a small memory and UART model.
module tb_mem_transfer_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_transfer_unit_if #(.WORD_BYTES(4), .ADDR_W(32), .TGT_W(2)) bus ();

   mem_transfer_unit dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Memory model (registered read) plus write and TX logs
   logic [31:0] mem [8];
   logic        preload = 1'b0;
   logic [31:0] wr_addr_log [64];
   logic [31:0] wr_data_log [64];
   logic [7:0]  tx_log [256];
   int          wr_cnt = 0;
   int          tx_cnt = 0;
   int          tx_cd  = 0;
   int          strobe_viol = 0;

   always @(posedge clk) begin
      if (preload) begin
         mem[0] <= 32'hDEADBEEF;
         mem[1] <= 32'h12345678;
      end else if (bus.mem_we_o) begin
         mem[bus.mem_addr_o[2:0]] <= bus.mem_wdata_o;
      end
      if (bus.mem_we_o) begin
         wr_addr_log[wr_cnt % 64] <= bus.mem_addr_o;
         wr_data_log[wr_cnt % 64] <= bus.mem_wdata_o;
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.mem_re_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[2:0]];
      if (bus.tx_start_o) begin
         tx_log[tx_cnt % 256] <= bus.tx_data_o;
         tx_cnt <= tx_cnt + 1;
      end
   end

   // UART TX model: tx_done a few cycles after each start
   always @(posedge clk) begin
      if (rst) begin
         tx_cd          <= 0;
         bus.tx_done_i  <= 1'b0;
      end else begin
         if (bus.tx_start_o) tx_cd <= 4;
         else if (tx_cd != 0) tx_cd <= tx_cd - 1;
         bus.tx_done_i <= (tx_cd == 1);
      end
   end

   always @(negedge clk) begin
      if ((int'(bus.mem_we_o) + int'(bus.mem_re_o) + int'(bus.tx_start_o)) > 1)
         strobe_viol <= strobe_viol + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data_i  = b;
      bus.rx_ready_i = 1'b1;
      @(negedge clk);
      bus.rx_ready_i = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_preload();
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bus.done_o && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_wait", {63'd0, bus.done_o}, 64'd1);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] cnt;
      int          npay;
      logic [63:0] pay;
      logic        send_csum;
      logic [7:0]  csum;
      int          nwr;
      logic [31:0] w0;
      logic [31:0] w1;
      int          ntx;
      logic [95:0] txb;
      logic [1:0]  tgt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int wr_base;
      int tx_base;
      int n;
      logic [63:0] pay;
      logic [95:0] txb;
      logic [31:0] w;

      // load good, load bad csum, dump 1 word, zero count, load to target 3, dump 2 words
      vecs[0] = '{8'h02, 16'd2, 8, 64'h8877665544332211, 1'b1, 8'h88, 2, 32'h44332211, 32'h88776655, 1, 96'hF1, 2'd1};
      vecs[1] = '{8'h02, 16'd2, 8, 64'h8877665544332211, 1'b1, 8'h00, 2, 32'h44332211, 32'h88776655, 1, 96'hE1, 2'd1};
      vecs[2] = '{8'h01, 16'd1, 0, 64'h0, 1'b0, 8'h00, 0, 32'h0, 32'h0, 6, 96'hF122DEADBEEF, 2'd0};
      vecs[3] = '{8'h00, 16'd0, 0, 64'h0, 1'b0, 8'h00, 0, 32'h0, 32'h0, 1, 96'hF1, 2'd0};
      vecs[4] = '{8'h06, 16'd1, 4, 64'h04030201, 1'b1, 8'h04, 1, 32'h04030201, 32'h0, 1, 96'hF1, 2'd3};
      vecs[5] = '{8'h07, 16'd2, 0, 64'h0, 1'b0, 8'h00, 0, 32'h0, 32'h0, 10, 96'h0000F12A12345678DEADBEEF, 2'd3};

      bus.grant_i    = 1'b0;
      bus.rx_data_i  = 8'h00;
      bus.rx_ready_i = 1'b0;
      bus.mem_rdata_i = 32'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_done",   {63'd0, bus.done_o}, 64'd0);
      check("rst_we",     {63'd0, bus.mem_we_o}, 64'd0);
      check("rst_txs",    {63'd0, bus.tx_start_o}, 64'd0);
      check("rst_addr",   {32'd0, bus.mem_addr_o}, 64'd0);
      check("rst_txdata", {56'd0, bus.tx_data_o}, 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         do_preload();
         wr_base = wr_cnt;
         tx_base = tx_cnt;
         pay = vecs[v].pay;
         txb = vecs[v].txb;
         bus.grant_i = 1'b1;
         send_rx(vecs[v].cmd);
         send_rx(vecs[v].cnt[15:8]);
         send_rx(vecs[v].cnt[7:0]);
         for (int i = 0; i < vecs[v].npay; i++) send_rx(pay[8*i +: 8]);
         if (vecs[v].send_csum) send_rx(vecs[v].csum);
         wait_done();
         check($sformatf("v%0d_target", v), {62'd0, bus.target_o}, {62'd0, vecs[v].tgt});
         check($sformatf("v%0d_nwr", v), 64'(wr_cnt - wr_base), 64'(vecs[v].nwr));
         for (int i = 0; i < vecs[v].nwr; i++) begin
            w = (i == 0) ? vecs[v].w0 : vecs[v].w1;
            check($sformatf("v%0d_waddr%0d", v, i), {32'd0, wr_addr_log[(wr_base + i) % 64]}, 64'(i));
            check($sformatf("v%0d_wdata%0d", v, i), {32'd0, wr_data_log[(wr_base + i) % 64]}, {32'd0, w});
         end
         check($sformatf("v%0d_ntx", v), 64'(tx_cnt - tx_base), 64'(vecs[v].ntx));
         for (int i = 0; i < vecs[v].ntx; i++)
            check($sformatf("v%0d_tx%0d", v, i), {56'd0, tx_log[(tx_base + i) % 256]}, {56'd0, txb[8*i +: 8]});
         @(negedge clk);
         check($sformatf("v%0d_done_held", v), {63'd0, bus.done_o}, 64'd1);
         bus.grant_i = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_done_clr", v), {63'd0, bus.done_o}, 64'd0);
         $display("vec %0d: cmd=%02h writes=%0d tx=%0d", v, vecs[v].cmd, wr_cnt - wr_base, tx_cnt - tx_base);
      end

      // Abort after 2 payload bytes: nothing written, nothing sent
      wr_base = wr_cnt;
      tx_base = tx_cnt;
      bus.grant_i = 1'b1;
      send_rx(8'h02); send_rx(8'h00); send_rx(8'h02);
      send_rx(8'h11); send_rx(8'h22);
      bus.grant_i = 1'b0;
      send_rx(8'h33); send_rx(8'h44);
      repeat (5) @(negedge clk);
      check("abort1_nwr", 64'(wr_cnt - wr_base), 64'd0);
      check("abort1_ntx", 64'(tx_cnt - tx_base), 64'd0);
      check("abort1_done", {63'd0, bus.done_o}, 64'd0);
      $display("abort1: writes=%0d tx=%0d", wr_cnt - wr_base, tx_cnt - tx_base);

      // Abort after one full word, then regrant must restart at address 0
      wr_base = wr_cnt;
      bus.grant_i = 1'b1;
      send_rx(8'h02); send_rx(8'h00); send_rx(8'h02);
      send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44); send_rx(8'h55);
      bus.grant_i = 1'b0;
      repeat (4) @(negedge clk);
      check("abort2_nwr", 64'(wr_cnt - wr_base), 64'd1);
      check("abort2_addr_held", {32'd0, bus.mem_addr_o}, 64'd1);
      wr_base = wr_cnt;
      tx_base = tx_cnt;
      bus.grant_i = 1'b1;
      @(negedge clk);
      check("regrant_addr", {32'd0, bus.mem_addr_o}, 64'd0);
      send_rx(8'h02); send_rx(8'h00); send_rx(8'h01);
      send_rx(8'hA1); send_rx(8'hB2); send_rx(8'hC3); send_rx(8'hD4); send_rx(8'h04);
      wait_done();
      check("regrant_nwr", 64'(wr_cnt - wr_base), 64'd1);
      check("regrant_waddr", {32'd0, wr_addr_log[wr_base % 64]}, 64'd0);
      check("regrant_wdata", {32'd0, wr_data_log[wr_base % 64]}, 64'hD4C3B2A1);
      check("regrant_ack", {56'd0, tx_log[tx_base % 256]}, 64'hF1);
      $display("abort2+regrant: writes=%0d tx=%0d", wr_cnt - wr_base, tx_cnt - tx_base);
      bus.grant_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during TX_WAIT of a dump
      do_preload();
      bus.grant_i = 1'b1;
      send_rx(8'h03); send_rx(8'h00); send_rx(8'h01);
      n = 0;
      while (!bus.tx_start_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rstdump_start_seen", {63'd0, bus.tx_start_o}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      bus.grant_i = 1'b0;
      #1;
      check("rstdump_txdata", {56'd0, bus.tx_data_o}, 64'd0);
      check("rstdump_target", {62'd0, bus.target_o}, 64'd0);
      check("rstdump_txs", {63'd0, bus.tx_start_o}, 64'd0);
      check("rstdump_re", {63'd0, bus.mem_re_o}, 64'd0);
      check("rstdump_wdata", {32'd0, bus.mem_wdata_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tx_base = tx_cnt;
      repeat (20) @(negedge clk);
      check("rstdump_no_tx", 64'(tx_cnt - tx_base), 64'd0);
      $display("reset_mid_dump: tx_after_release=%0d", tx_cnt - tx_base);

      check("strobe_excl", 64'(strobe_viol), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_transfer_unit.md
MEM_TRANSFER_UNIT -- requirements
Module: mem_transfer_unit

Interface
REQ-001 Parameter: WORD_BYTES, 4, bytes per memory word (1..8).
REQ-002 Parameter: ADDR_W, 32, memory address width.
REQ-003 Parameter: COUNT_W, 16, word-count width (multiple of 8).
REQ-004 Parameter: TGT_W, 2, target-select width (up to 2^TGT_W memories).
REQ-005 Parameter: ACK_OK, 8'hF1, completion byte on success.
REQ-006 Parameter: ACK_ERR, 8'hE1, completion byte on checksum mismatch.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-008 Port: clk_i, in, 1, clock.
REQ-009 Port: rst_i, in, 1, asynchronous active-high reset.
REQ-010 Port: grant_i, in, 1, arbiter enable.
REQ-011 Port: done_o, out, 1, completion flag to arbiter.
REQ-012 Port: target_o, out, TGT_W, latched memory select.
REQ-013 Port: rx_data_i / rx_ready_i, in, 8 / 1, UART RX byte and 1-cycle valid.
REQ-014 Port: tx_data_o / tx_start_o, out, 8 / 1, UART TX byte and 1-cycle start.
REQ-015 Port: tx_done_i, in, 1, UART TX byte finished.
REQ-016 Port: mem_we_o / mem_re_o, out, 1 / 1, write strobe / read strobe.
REQ-017 Port: mem_addr_o, out, ADDR_W, word address.
REQ-018 Port: mem_wdata_o / mem_rdata_i, out / in, 8*WORD_BYTES, write data / read data.

Function
REQ-019 States: IDLE, CMD, CNT, RX_BYTE, WRITE, RX_CSUM, READ, TX_BYTE, TX_WAIT, TX_CSUM, CSUM_WAIT, ACK, ACK_WAIT, DONE.
REQ-020 IDLE: on grant_i, clear the address, word count, byte index and checksum, then go to CMD.
REQ-021 CMD: on rx_ready_i, latch bit0 as mode (0=load, 1=dump) and bits[TGT_W:1] into target_o, then go to CNT.
REQ-022 CNT: take COUNT_W/8 bytes, MSB first, into the word count.
REQ-023 After the last count byte: if count=0, go to ACK with status OK; otherwise go to RX_BYTE (load) or READ (dump).
REQ-024 RX_BYTE: bytes arrive little-endian; byte k fills bits [8k+7:8k]; each byte is XORed into the 8-bit checksum; after WORD_BYTES bytes, go to WRITE.
REQ-025 WRITE: hold mem_we_o high for exactly 1 cycle with the current address and the assembled word; address +1, words +1; go to RX_CSUM if words equals count, else back to RX_BYTE.
REQ-026 RX_CSUM: on rx_ready_i, compare the received byte with the checksum; equal gives status OK, otherwise ERR; go to ACK.
REQ-027 READ: pulse mem_re_o for 1 cycle; mem_rdata_i is valid on the next cycle and is captured then (1-cycle read latency); go to TX_BYTE.
REQ-028 TX_BYTE: pulse tx_start_o with the captured word's byte index, little-endian, and XOR that byte into the checksum; go to TX_WAIT.
REQ-029 TX_WAIT: on tx_done_i, send the next byte; after the last byte, advance address and word count, then go to READ or, once all words are sent, to TX_CSUM.
REQ-030 TX_CSUM: pulse tx_start_o with the checksum byte; go to CSUM_WAIT; on tx_done_i, set status OK and go to ACK.
REQ-031 ACK: pulse tx_start_o with ACK_OK or ACK_ERR; hold tx_data_o until tx_done_i in ACK_WAIT, then go to DONE.
REQ-032 DONE: hold done_o high; go to IDLE when grant_i is low.
REQ-033 Grant drop: grant_i low in any state other than IDLE or DONE aborts to IDLE next cycle; no further strobes are issued.
REQ-034 Strobes: mem_we_o, mem_re_o and tx_start_o are never high at the same time; rx_ready_i is ignored in all states except CMD, CNT, RX_BYTE and RX_CSUM.
REQ-035 Address arithmetic: mem_addr_o wraps modulo 2^ADDR_W; word count compares as unsigned COUNT_W; count 2^COUNT_W-1 is legal.
REQ-036 Undefined state encoding goes to IDLE.

Reset
REQ-037 While rst_i is high (asynchronous): state=IDLE; done_o, mem_we_o, mem_re_o and tx_start_o are 0; tx_data_o, mem_addr_o, mem_wdata_o and target_o are 0; checksum, counters and byte index are 0.
REQ-038 Reset asserted mid-transfer: no partial word is written; the first action after release is the IDLE grant check.

Verification
REQ-039 Load test: cmd 8'h02, count 00 02, bytes 11 22 33 44 55 66 77 88, csum 8'h88 -> writes 44332211@0 and 88776655@1, TX F1, done_o high.
REQ-040 Bad checksum: same load with csum 8'h00 -> both words still written, TX E1.
REQ-041 Dump test: cmd 8'h01, count 00 01, mem[0]=DEADBEEF -> TX EF BE AD DE, then 8'h22 (checksum), then F1.
REQ-042 Zero count: cmd 8'h00, count 00 00 -> no mem strobe, TX F1, done_o high until grant_i drops.
REQ-043 Abort: grant_i drops after 2 payload bytes -> IDLE next cycle, mem_we_o never asserts; the next grant restarts at address 0.
REQ-044 Reset mid-dump, during TX_WAIT: all outputs 0 immediately; no tx_start_o after release until a new grant.
